// File: rtl/regfile_write_arbiter_pkg.sv
// regfile_write_arbiter_pkg
// Purpose: shared widths, state encoding and debug-entry layout for the
//          register-file write-port arbiter and its debug FIFO.
// Ports:   none (package).
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  // Same register index as the register file's user-number slot; debug
  // traffic must never overwrite it.
  localparam int PROTECTED_REG_DEFAULT = 30;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] reg_idx;
    logic [DATA_W-1:0]     data;
  } dbg_entry_t;

  localparam int ENTRY_W = REG_ADDR_W + DATA_W;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
// Purpose: bundles the CPU writeback request, the debug write handshake and
//          the register-file write port into one interface.
// Modports:
//   slave  - arbiter side: takes wb_*/dbg_* requests, drives dbg_ready,
//            dbg_drop, cpu_stall and the RegWrite/writeRegister/writeData port.
//   master - requester/register-file side (the opposite directions).
interface regfile_write_arbiter_if;
  import regfile_write_arbiter_pkg::*;

  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic                  dbg_valid;
  logic [REG_ADDR_W-1:0] dbg_reg;
  logic [DATA_W-1:0]     dbg_data;
  logic                  dbg_ready;
  logic                  dbg_drop;
  logic                  cpu_stall;
  logic                  RegWrite;
  logic [REG_ADDR_W-1:0] writeRegister;
  logic [DATA_W-1:0]     writeData;

  modport slave (
    input  wb_en, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    output dbg_ready, dbg_drop, cpu_stall, RegWrite, writeRegister, writeData
  );

  modport master (
    output wb_en, wb_reg, wb_data, dbg_valid, dbg_reg, dbg_data,
    input  dbg_ready, dbg_drop, cpu_stall, RegWrite, writeRegister, writeData
  );

endinterface

// File: rtl/regfile_write_arbiter_dbg_write_fifo.sv
// dbg_write_fifo
// Purpose: small synchronous FIFO holding queued debug writes.
// Ports:
//   i_clock  - clock, posedge
//   i_reset  - synchronous active-high reset; empties the FIFO
//   i_push   - write i_data (ignored when full)
//   i_pop    - discard head (ignored when empty)
//   i_data   - entry to push
//   o_full   - no room for another entry
//   o_empty  - nothing queued
//   o_head   - oldest entry (undefined when empty)
module dbg_write_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // One extra pointer bit separates full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Purpose: shares the register file's single write port between CPU
//          writeback (normal priority) and queued debug writes, with a
//          starvation guard that stalls the CPU for one cycle.
// Ports:
//   clock - sole clock, posedge
//   reset - synchronous active-high reset
//   bus   - regfile_write_arbiter_if.slave: CPU writeback request, debug
//           push handshake, dbg_drop, cpu_stall and the register-file write
//           port (RegWrite/writeRegister/writeData, combinational).
//
// state    | meaning
// ST_RUN   | CPU wins when wb_en; idle slots drain the debug FIFO
// ST_STALL | CPU held for one cycle; debug head is granted
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DBG_DEPTH     = 4,
  parameter int STARVE_LIMIT  = 8,
  parameter int PROTECTED_REG = PROTECTED_REG_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  regfile_write_arbiter_if.slave  bus
);

  localparam int                    WCNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [WCNT_W-1:0]     LIMIT_C = WCNT_W'(STARVE_LIMIT);
  localparam logic [REG_ADDR_W-1:0] PROT_C  = REG_ADDR_W'(PROTECTED_REG);

  state_t              r_state, w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nxt, w_wcnt_inc;
  logic                w_full, w_empty, w_push, w_pop, w_dbg_ready;
  dbg_entry_t          w_head, w_push_entry;
  logic                w_regwrite, w_drop, w_stall;
  logic [REG_ADDR_W-1:0] w_wreg;
  logic [DATA_W-1:0]     w_wdata;

  assign w_dbg_ready          = ~w_full & ~reset;
  assign w_push               = bus.dbg_valid & w_dbg_ready;
  assign w_push_entry.reg_idx = bus.dbg_reg;
  assign w_push_entry.data    = bus.dbg_data;
  assign w_wcnt_inc           = r_wcnt + 1'b1;

  dbg_write_fifo #(
    .DEPTH (DBG_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_clock (clock),
    .i_reset (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_pop       = 1'b0;
    w_regwrite  = 1'b0;
    w_wreg      = '0;
    w_wdata     = '0;
    w_drop      = 1'b0;
    w_stall     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.wb_en) begin
          w_regwrite = 1'b1;
          w_wreg     = bus.wb_reg;
          w_wdata    = bus.wb_data;
          if (!w_empty) begin
            w_wcnt_nxt = w_wcnt_inc;
            if (w_wcnt_inc == LIMIT_C) w_state_nxt = ST_STALL;
          end
        end else begin
          w_wcnt_nxt = '0;
          w_pop      = ~w_empty;
        end
      end
      ST_STALL: begin
        w_stall     = 1'b1;
        w_pop       = ~w_empty;
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wcnt_nxt  = '0;
      end
    endcase

    // A debug grant to the protected register still consumes the slot.
    if (w_pop) begin
      if (w_head.reg_idx == PROT_C) begin
        w_drop = 1'b1;
      end else begin
        w_regwrite = 1'b1;
        w_wreg     = w_head.reg_idx;
        w_wdata    = w_head.data;
      end
    end
  end

  assign bus.dbg_ready     = w_dbg_ready;
  assign bus.dbg_drop      = w_drop;
  assign bus.cpu_stall     = w_stall;
  assign bus.RegWrite      = w_regwrite;
  assign bus.writeRegister = w_wreg;
  assign bus.writeData     = w_wdata;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Purpose: directed scoreboard bench for regfile_write_arbiter. Stimulus
//          queues the expected write-port events; a negedge monitor pops and
//          compares every RegWrite/dbg_drop the DUT presents.
module tb_regfile_write_arbiter;
  import regfile_write_arbiter_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit          drop;
    logic [4:0]  r;
    logic [31:0] d;
  } ev_t;

  ev_t  sb[$];
  ev_t  mon_e;
  int   assert_cnt = 0;
  int   fail_cnt   = 0;
  bit   mon_en     = 1'b0;
  logic [2:0] occ;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_wr(input logic [4:0] r, input logic [31:0] d);
    ev_t e;
    e.drop = 1'b0; e.r = r; e.d = d;
    sb.push_back(e);
  endtask

  task automatic exp_drop();
    ev_t e;
    e.drop = 1'b1; e.r = '0; e.d = '0;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic cpu(input logic en, input logic [4:0] r, input logic [31:0] d);
    bus.wb_en = en; bus.wb_reg = r; bus.wb_data = d;
  endtask

  task automatic dbg(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.dbg_valid = v; bus.dbg_reg = r; bus.dbg_data = d;
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (bus.RegWrite || bus.dbg_drop) begin
        assert_cnt++;
        if (sb.size() == 0) begin
          fail_cnt++;
          $display("FAIL sb_unexpected: RegWrite=%0b drop=%0b reg=%0d data=%h, expected no event (t=%0t)",
                   bus.RegWrite, bus.dbg_drop, bus.writeRegister, bus.writeData, $time);
        end else begin
          mon_e = sb.pop_front();
          if (mon_e.drop) begin
            if (!(bus.dbg_drop && !bus.RegWrite)) begin
              fail_cnt++;
              $display("FAIL sb_drop: RegWrite=%0b drop=%0b, expected drop=1 RegWrite=0 (t=%0t)",
                       bus.RegWrite, bus.dbg_drop, $time);
            end
          end else if (!(bus.RegWrite && !bus.dbg_drop &&
                         bus.writeRegister === mon_e.r && bus.writeData === mon_e.d)) begin
            fail_cnt++;
            $display("FAIL sb_write: RegWrite=%0b drop=%0b reg=%0d data=%h, expected write reg=%0d data=%h (t=%0t)",
                     bus.RegWrite, bus.dbg_drop, bus.writeRegister, bus.writeData, mon_e.r, mon_e.d, $time);
          end
        end
      end else begin
        assert_cnt++;
        if (bus.writeRegister !== 5'd0 || bus.writeData !== 32'd0) begin
          fail_cnt++;
          $display("FAIL idle_zero: reg=%0d data=%h, expected 0/0 (t=%0t)",
                   bus.writeRegister, bus.writeData, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cpu(1'b0, 5'd0, 32'd0);
    dbg(1'b0, 5'd0, 32'd0);
    step();
    step();
    chk("rst_stall",  bus.cpu_stall, 0);
    chk("rst_drop",   bus.dbg_drop,  0);
    chk("rst_regwr",  bus.RegWrite,  0);
    chk("rst_ready",  bus.dbg_ready, 0);

    // Idle CPU, single debug write
    reset  = 1'b0;
    mon_en = 1'b1;
    dbg(1'b1, 5'd5, 32'hDEADBEEF);
    exp_wr(5'd5, 32'hDEADBEEF);
    #1;
    chk("t1_ready", bus.dbg_ready, 1);
    chk("t1_no_wr_push_cycle", bus.RegWrite, 0);
    step();
    dbg(1'b0, 5'd0, 32'd0);
    #1;
    chk("t1_wr", bus.RegWrite, 1);
    chk("t1_wreg", bus.writeRegister, 5);
    step();
    #1;
    chk("t1_empty_after", bus.RegWrite, 0);
    step();

    // Starvation guard: 1 entry queued behind continuous CPU writes to r3
    for (int k = 0; k < 9; k++) begin
      cpu(1'b1, 5'd3, 32'h3000_0000 + k);
      if (k == 0) dbg(1'b1, 5'd12, 32'hA5A5_0012);
      else        dbg(1'b0, 5'd0, 32'd0);
      exp_wr(5'd3, 32'h3000_0000 + k);
      #1;
      chk("t2_no_stall", bus.cpu_stall, 0);
      step();
    end
    cpu(1'b1, 5'd3, 32'h3000_0009);
    exp_wr(5'd12, 32'hA5A5_0012);
    #1;
    chk("t2_stall", bus.cpu_stall, 1);
    step();
    exp_wr(5'd3, 32'h3000_0009);
    #1;
    chk("t2_resume", bus.cpu_stall, 0);
    chk("t2_wcnt_clr", 32'(dut.r_wcnt), 0);
    step();
    cpu(1'b1, 5'd30, 32'h3000_000A);
    exp_wr(5'd30, 32'h3000_000A);
    #1;
    chk("t2_cpu_prot_nodrop", bus.dbg_drop, 0);
    step();
    cpu(1'b0, 5'd0, 32'd0);
    step();

    // Fill FIFO to full while CPU is busy, then drain
    for (int i = 0; i < 4; i++) begin
      cpu(1'b1, 5'd7, 32'h7000_0000 + i);
      dbg(1'b1, 5'(16 + i), 32'hF0F0_0000 + i);
      exp_wr(5'd7, 32'h7000_0000 + i);
      #1;
      chk("t3_ready_fill", bus.dbg_ready, 1);
      step();
    end
    cpu(1'b1, 5'd7, 32'h7000_0004);
    dbg(1'b1, 5'd20, 32'hF0F0_0004);
    exp_wr(5'd7, 32'h7000_0004);
    #1;
    chk("t3_ready_full", bus.dbg_ready, 0);
    step();
    cpu(1'b0, 5'd0, 32'd0);
    dbg(1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 4; i++) exp_wr(5'(16 + i), 32'hF0F0_0000 + i);
    for (int i = 0; i < 5; i++) step();

    // Protected-register debug entry is dropped, next one granted after
    cpu(1'b1, 5'd1, 32'h11);
    dbg(1'b1, 5'd30, 32'h1234);
    exp_wr(5'd1, 32'h11);
    step();
    cpu(1'b1, 5'd1, 32'h22);
    dbg(1'b1, 5'd9, 32'h5555);
    exp_wr(5'd1, 32'h22);
    step();
    cpu(1'b0, 5'd0, 32'd0);
    dbg(1'b0, 5'd0, 32'd0);
    exp_drop();
    #1;
    chk("t4_drop", bus.dbg_drop, 1);
    chk("t4_drop_nowr", bus.RegWrite, 0);
    step();
    exp_wr(5'd9, 32'h5555);
    #1;
    chk("t4_drop_pulse", bus.dbg_drop, 0);
    chk("t4_next_wr", bus.RegWrite, 1);
    step();
    step();

    // Simultaneous push and pop at occupancy 2
    cpu(1'b1, 5'd2, 32'h21);
    dbg(1'b1, 5'd10, 32'hAAAA_0001);
    exp_wr(5'd2, 32'h21);
    step();
    cpu(1'b1, 5'd2, 32'h22);
    dbg(1'b1, 5'd11, 32'hAAAA_0002);
    exp_wr(5'd2, 32'h22);
    step();
    cpu(1'b0, 5'd0, 32'd0);
    dbg(1'b1, 5'd12, 32'hAAAA_0003);
    exp_wr(5'd10, 32'hAAAA_0001);
    #1;
    chk("t5_ready", bus.dbg_ready, 1);
    step();
    dbg(1'b0, 5'd0, 32'd0);
    occ = dut.u_fifo.r_wr_ptr - dut.u_fifo.r_rd_ptr;
    chk("t5_occupancy", 32'(occ), 2);
    exp_wr(5'd11, 32'hAAAA_0002);
    exp_wr(5'd12, 32'hAAAA_0003);
    step();
    step();
    step();

    // Reset during STALL with 3 entries queued
    for (int k = 0; k < 9; k++) begin
      cpu(1'b1, 5'd4, 32'h4000_0000 + k);
      if (k < 3) dbg(1'b1, 5'(20 + k), 32'hBB00_0000 + k);
      else       dbg(1'b0, 5'd0, 32'd0);
      exp_wr(5'd4, 32'h4000_0000 + k);
      step();
    end
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("t6_in_stall", bus.cpu_stall, 1);
    step();
    cpu(1'b0, 5'd0, 32'd0);
    #1;
    chk("t6_rst_stall", bus.cpu_stall, 0);
    chk("t6_rst_ready", bus.dbg_ready, 0);
    chk("t6_rst_regwr", bus.RegWrite, 0);
    chk("t6_rst_drop",  bus.dbg_drop, 0);
    step();
    reset  = 1'b0;
    mon_en = 1'b1;
    #1;
    chk("t6_ready_after", bus.dbg_ready, 1);
    chk("t6_no_stale", bus.RegWrite, 0);
    for (int i = 0; i < 4; i++) step();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the register file's single write port between the CPU writeback stage and a debug/host loader. CPU writes normally win. Debug writes are queued in a small FIFO and drained on idle writeback cycles. A starvation guard stalls the CPU for one cycle when debug traffic has waited too long. The block sits directly in front of the register file's `RegWrite`/`writeRegister`/`writeData` inputs.

## Interface
- `DBG_DEPTH`, 4: debug FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 8: consecutive cycles a non-empty FIFO may lose arbitration before a stall is forced (≥1).
- `PROTECTED_REG`, 30: register index that debug writes may not target.

Ports:
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `wb_en`  in  1  CPU writeback request.
- `wb_reg`  in  5  CPU destination register.
- `wb_data`  in  32  CPU write data.
- `dbg_valid`  in  1  debug write offered.
- `dbg_reg`  in  5  debug destination register.
- `dbg_data`  in  32  debug write data.
- `dbg_ready`  out  1  FIFO can accept (push when `dbg_valid & dbg_ready`).
- `dbg_drop`  out  1  one-cycle pulse: head entry targeted `PROTECTED_REG` and was discarded.
- `cpu_stall`  out  1  CPU must hold writeback and pipeline this cycle.
- `RegWrite`  out  1  to register file.
- `writeRegister`  out  5  to register file.
- `writeData`  out  32  to register file.

## Operation
- The FIFO holds {reg, data}. Push requires `dbg_valid & dbg_ready`. `dbg_ready = !full & !reset`. There is no push-while-full, even when a pop happens in the same cycle.
- State machine has two states, RUN and STALL, with a wait counter `wcnt` (width ⌈log2(STARVE_LIMIT+1)⌉).
- RUN, `wb_en=1`: the CPU wins. Outputs are `RegWrite=1`, `writeRegister=wb_reg`, `writeData=wb_data`.
  - If the FIFO is non-empty, `wcnt` increments.
  - When the incremented value equals `STARVE_LIMIT`, next state is STALL.
- RUN, `wb_en=0`, FIFO non-empty: debug head is granted and popped, and `wcnt` is cleared.
- RUN, `wb_en=0`, FIFO empty: `RegWrite=0` and `wcnt` is cleared.
- STALL: `cpu_stall=1`. CPU inputs are ignored (the CPU holds them). Debug head is granted and popped. Next state is RUN with `wcnt=0`.
- Debug grant whose head `reg == PROTECTED_REG`: the entry is popped, `RegWrite=0`, and `dbg_drop=1` for that cycle. The grant slot is consumed.
- CPU writes to any register, including `PROTECTED_REG`, pass through unchanged.
- When `RegWrite=0`, `writeRegister`/`writeData` are 0.
- Push and pop in the same cycle when non-empty and not full: both occur and occupancy is unchanged.

## Timing
- Write-port outputs are combinational from current inputs, FIFO head, and state: zero latency, same cycle.
- `cpu_stall` and `dbg_drop` are decoded from registered state and the FIFO head; they are valid for the whole cycle.
- A debug write accepted at edge N is eligible for grant in cycle N+1 at the earliest, so a push into an empty FIFO is written the following cycle if `wb_en=0`.
- Worst-case debug wait for the head is `STARVE_LIMIT` CPU-won cycles plus 1 stall cycle.
- Reset, applied at any point including mid-STALL:
  - Next-cycle state is RUN with `wcnt=0`, FIFO empty, and pointers at 0.
  - Outputs are `cpu_stall=0`, `dbg_drop=0`, `RegWrite=0`.
  - `dbg_ready=0` while `reset` is high.
  - Queued entries are discarded.
- Pointer wrap-around is modulo `DBG_DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Structure
- Shared package/header:
  - `REG_ADDR_W=5`, `DATA_W=32`.
  - State encodings `ST_RUN`, `ST_STALL`.
  - The `PROTECTED_REG` default, shared with the register file's user-number slot.
- Sub-module `dbg_write_fifo`: synchronous FIFO, parameterised depth/width, with ports push, pop, full, empty, head. It is instantiated once.
- The top holds the state machine, the counter, and the write-port mux.

## Test plan
- Idle CPU, push {reg 5, 0xDEADBEEF}: `dbg_ready=1` at push. Next cycle `RegWrite=1`, `writeRegister=5`, `writeData=0xDEADBEEF`, and the FIFO is empty after.
- `wb_en=1` continuously with `wb_reg=3` and 1 debug entry queued, `STARVE_LIMIT=8`:
  - 8 CPU writes to r3.
  - Then 1 cycle with `cpu_stall=1` and the debug write performed.
  - Then CPU writes resume and `wcnt=0`.
- Push 4 entries with no pop: `dbg_ready=0` after the 4th. A 5th `dbg_valid` is not accepted. Draining yields all 4 in order.
- Debug entry {reg 30, 0x1234} granted: `RegWrite=0`, `dbg_drop=1` for 1 cycle. The next entry is granted the following cycle.
- Simultaneous push and pop at occupancy 2: occupancy stays 2 and order is preserved.
- Assert `reset` during STALL with 3 entries queued:
  - Next cycle `cpu_stall=0`, FIFO empty, `dbg_ready=0`.
  - After reset deasserts, `dbg_ready=1` and no stale writes appear.
